// File: rtl/edge_host_pkg.sv
// Shared types and constants for the edge-detect job launcher.
package edge_host_pkg;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SIZE,
      ST_SRC,
      ST_DST,
      ST_WAIT,
      ST_FINISH
   } state_t;

   localparam int MIN_DIM    = 3;
   localparam int SIZE_W_MSB = 31;
   localparam int SIZE_W_LSB = 16;
   localparam int SIZE_H_MSB = 15;
   localparam int SIZE_H_LSB = 0;

   // Width occupies the upper half of the size word, height the lower half.
   function automatic logic [31:0] size_word(input logic [15:0] w, input logic [15:0] h);
      logic [31:0] word;
      word = '0;
      word[SIZE_W_MSB:SIZE_W_LSB] = w;
      word[SIZE_H_MSB:SIZE_H_LSB] = h;
      return word;
   endfunction
endpackage

// File: rtl/flex_counter.sv
// Free-running up-counter with synchronous clear and count enable.
module flex_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clear,
   input  logic             count_enable,
   output logic [WIDTH-1:0] count_out
);
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)            count_out <= '0;
      else if (clear)        count_out <= '0;
      else if (count_enable) count_out <= count_out + WIDTH'(1);
   end
endmodule

// File: rtl/job_launcher.sv
// Launches one edge-detect job: writes size/src/dst config words, then waits for completion.
// Define JOB_LAUNCHER_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT_CYCLES cycles.
module job_launcher
   import edge_host_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        start,
   input  logic [15:0] img_width,
   input  logic [15:0] img_height,
   input  logic [31:0] src_addr,
   input  logic [31:0] dst_addr,
   input  logic        job_done,
   output logic        HREADY_S,
   output logic        HWRITE_S,
   output logic [31:0] HADDR_S,
   output logic [31:0] HWDATA_S,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] job_count
);
   state_t      state_q, state_d;
   logic [15:0] width_q, height_q;
   logic [31:0] src_q, dst_q;
   logic        err_q, err_d;
   logic        latch_en;
   logic        wd_expired;

`ifdef JOB_LAUNCHER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CNT_W-1:0] wd_cnt;

   // Cleared during DST so the first WAIT cycle sees count 0.
   flex_counter #(.WIDTH(CNT_W)) u_wdog (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (state_q == ST_DST),
      .count_enable (state_q == ST_WAIT),
      .count_out    (wd_cnt)
   );
   assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign wd_expired = 1'b0;
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= ST_IDLE;
         err_q     <= 1'b0;
         width_q   <= '0;
         height_q  <= '0;
         src_q     <= '0;
         dst_q     <= '0;
         job_count <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         if (latch_en) begin
            width_q  <= img_width;
            height_q <= img_height;
            src_q    <= src_addr;
            dst_q    <= dst_addr;
         end
         if (state_q == ST_FINISH) job_count <= job_count + 16'd1;
      end
   end

   always_comb begin
      state_d  = state_q;
      err_d    = 1'b0;
      latch_en = 1'b0;
      case (state_q)
         ST_IDLE:
            if (start) begin
               if (img_width >= 16'(MIN_DIM) && img_height >= 16'(MIN_DIM)) begin
                  latch_en = 1'b1;
                  state_d  = ST_SIZE;
               end else begin
                  err_d = 1'b1;
               end
            end
         ST_SIZE:   state_d = ST_SRC;
         ST_SRC:    state_d = ST_DST;
         ST_DST:    state_d = ST_WAIT;
         // Completion wins over a watchdog expiry in the same cycle.
         ST_WAIT:
            if (job_done) begin
               state_d = ST_FINISH;
            end else if (wd_expired) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      HREADY_S = 1'b0;
      HWRITE_S = 1'b0;
      HADDR_S  = '0;
      HWDATA_S = '0;
      case (state_q)
         ST_SIZE: begin
            HREADY_S = 1'b1;
            HWRITE_S = 1'b1;
            HADDR_S  = src_q;
            HWDATA_S = size_word(width_q, height_q);
         end
         ST_SRC: begin
            HREADY_S = 1'b1;
            HWRITE_S = 1'b1;
            HADDR_S  = src_q;
            HWDATA_S = src_q;
         end
         ST_DST: begin
            HREADY_S = 1'b1;
            HWRITE_S = 1'b1;
            HADDR_S  = dst_q;
            HWDATA_S = dst_q;
         end
         default: ;
      endcase
   end

   assign busy  = (state_q != ST_IDLE);
   assign done  = (state_q == ST_FINISH);
   assign error = err_q;
endmodule

// File: tb/tb_job_launcher.sv
// Directed bench for job_launcher; timeout steps run when JOB_LAUNCHER_TIMEOUT_EN is defined.
module tb_job_launcher;
   logic        tb_clk = 1'b0;
   logic        n_rst, start, job_done;
   logic [15:0] img_width, img_height;
   logic [31:0] src_addr, dst_addr;
   logic        HREADY_S, HWRITE_S, busy, done, error;
   logic [31:0] HADDR_S, HWDATA_S;
   logic [15:0] job_count;
   logic [15:0] cnt_exp;
   int          passed = 0, total = 0, failed = 0;

   always #5 tb_clk = ~tb_clk;

   job_launcher #(.TIMEOUT_CYCLES(16)) dut (
      .clk(tb_clk), .n_rst(n_rst), .start(start), .img_width(img_width),
      .img_height(img_height), .src_addr(src_addr), .dst_addr(dst_addr),
      .job_done(job_done), .HREADY_S(HREADY_S), .HWRITE_S(HWRITE_S),
      .HADDR_S(HADDR_S), .HWDATA_S(HWDATA_S), .busy(busy), .done(done),
      .error(error), .job_count(job_count)
   );

   // Packed order: busy, HREADY_S, HWRITE_S, done, error, job_count, HADDR_S, HWDATA_S
   function automatic logic [84:0] ex(input logic b, input logic r, input logic w,
                                      input logic d, input logic e, input logic [15:0] c,
                                      input logic [31:0] a, input logic [31:0] dt);
      return {b, r, w, d, e, c, a, dt};
   endfunction

   task automatic chk(input string tag, input logic [84:0] exp_v);
      logic [84:0] act;
      act = {busy, HREADY_S, HWRITE_S, done, error, job_count, HADDR_S, HWDATA_S};
      total++;
      assert (act === exp_v) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, act, exp_v);
      end
   endtask

   task automatic tick();
      @(negedge tb_clk);
   endtask

   task automatic launch(input logic [15:0] w, input logic [15:0] h,
                         input logic [31:0] s, input logic [31:0] d);
      start = 1'b1; img_width = w; img_height = h; src_addr = s; dst_addr = d;
      tick();
      start = 1'b0;
   endtask

   initial begin
      n_rst = 1'b0; start = 1'b0; job_done = 1'b0;
      img_width = '0; img_height = '0; src_addr = '0; dst_addr = '0;
      cnt_exp = 16'd0;
      tick(); tick();
      chk("reset", ex(0,0,0,0,0,16'd0,32'd0,32'd0));
      n_rst = 1'b1;
      tick();

      // Nominal 400x400 job, completion 10 cycles into WAIT
      launch(16'd400, 16'd400, 32'd0, 32'd200000);
      chk("j1_size", ex(1,1,1,0,0,cnt_exp,32'd0,32'h01900190));
      tick(); chk("j1_src",  ex(1,1,1,0,0,cnt_exp,32'd0,32'd0));
      tick(); chk("j1_dst",  ex(1,1,1,0,0,cnt_exp,32'h00030D40,32'h00030D40));
      tick(); chk("j1_wait", ex(1,0,0,0,0,cnt_exp,32'd0,32'd0));
      repeat (9) tick();
      chk("j1_wait10", ex(1,0,0,0,0,cnt_exp,32'd0,32'd0));
      job_done = 1'b1;
      tick(); job_done = 1'b0;
      chk("j1_finish", ex(1,0,0,1,0,cnt_exp,32'd0,32'd0));
      cnt_exp = 16'd1;
      tick(); chk("j1_idle", ex(0,0,0,0,0,cnt_exp,32'd0,32'd0));

      // Rejected starts on each undersized dimension
      launch(16'd2, 16'd10, 32'h10, 32'h20);
      chk("rej_w_err", ex(0,0,0,0,1,cnt_exp,32'd0,32'd0));
      tick(); chk("rej_w_after", ex(0,0,0,0,0,cnt_exp,32'd0,32'd0));
      launch(16'd3, 16'd2, 32'h10, 32'h20);
      chk("rej_h_err", ex(0,0,0,0,1,cnt_exp,32'd0,32'd0));
      tick(); chk("rej_h_after", ex(0,0,0,0,0,cnt_exp,32'd0,32'd0));

      // Minimum 3x3 job; stray job_done in SRC and start in WAIT are ignored
      launch(16'd3, 16'd3, 32'h1000, 32'h2000);
      chk("j2_size", ex(1,1,1,0,0,cnt_exp,32'h1000,32'h00030003));
      tick(); chk("j2_src", ex(1,1,1,0,0,cnt_exp,32'h1000,32'h1000));
      job_done = 1'b1; img_width = 16'd999; src_addr = 32'hDEAD; dst_addr = 32'hBEEF;
      tick(); job_done = 1'b0;
      chk("j2_dst", ex(1,1,1,0,0,cnt_exp,32'h2000,32'h2000));
      tick(); chk("j2_wait", ex(1,0,0,0,0,cnt_exp,32'd0,32'd0));
      start = 1'b1; img_width = 16'd400;
      tick(); start = 1'b0;
      chk("j2_wait_start", ex(1,0,0,0,0,cnt_exp,32'd0,32'd0));
      job_done = 1'b1;
      tick(); job_done = 1'b0;
      chk("j2_finish", ex(1,0,0,1,0,cnt_exp,32'd0,32'd0));
      cnt_exp = 16'd2;
      tick(); chk("j2_idle", ex(0,0,0,0,0,cnt_exp,32'd0,32'd0));

`ifdef JOB_LAUNCHER_TIMEOUT_EN
      // Watchdog expires after 16 WAIT cycles
      launch(16'd3, 16'd3, 32'h4, 32'h8);
      tick(); tick(); tick();
      for (int i = 0; i < 15; i++) begin
         chk("to_wait", ex(1,0,0,0,0,cnt_exp,32'd0,32'd0));
         tick();
      end
      chk("to_wait16", ex(1,0,0,0,0,cnt_exp,32'd0,32'd0));
      tick(); chk("to_error", ex(0,0,0,0,1,cnt_exp,32'd0,32'd0));
      tick(); chk("to_after", ex(0,0,0,0,0,cnt_exp,32'd0,32'd0));
      // Completion on the terminal cycle beats the watchdog
      launch(16'd3, 16'd3, 32'h4, 32'h8);
      tick(); tick(); tick();
      repeat (15) tick();
      job_done = 1'b1;
      tick(); job_done = 1'b0;
      chk("to_done_wins", ex(1,0,0,1,0,cnt_exp,32'd0,32'd0));
      cnt_exp = cnt_exp + 16'd1;
      tick(); chk("to_done_idle", ex(0,0,0,0,0,cnt_exp,32'd0,32'd0));
`endif

      // Reset during DST abandons the job immediately
      launch(16'd5, 16'd6, 32'h100, 32'h200);
      tick(); tick();
      chk("rst_dst", ex(1,1,1,0,0,cnt_exp,32'h200,32'h200));
      n_rst = 1'b0;
      #1;
      cnt_exp = 16'd0;
      chk("rst_async", ex(0,0,0,0,0,cnt_exp,32'd0,32'd0));
      tick(); n_rst = 1'b1;
      tick(); chk("rst_quiet", ex(0,0,0,0,0,cnt_exp,32'd0,32'd0));

      // job_count wraps from 0xFFFF to 0
      force dut.job_count = 16'hFFFF;
      tick();
      release dut.job_count;
      cnt_exp = 16'hFFFF;
      tick(); chk("wrap_preload", ex(0,0,0,0,0,cnt_exp,32'd0,32'd0));
      launch(16'd3, 16'd3, 32'h0, 32'h0);
      tick(); tick(); tick();
      job_done = 1'b1;
      tick(); job_done = 1'b0;
      chk("wrap_finish", ex(1,0,0,1,0,cnt_exp,32'd0,32'd0));
      cnt_exp = 16'h0000;
      tick(); chk("wrap_zero", ex(0,0,0,0,0,cnt_exp,32'd0,32'd0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
